spike_rate_decoder: RTL and testbench

Receive side of the neuron spike interface. The block takes the single-bit spike line driven by a `neuron` instance and turns it into a spike count per fixed window, which downstream logic uses as a firing rate. Each count is presented through a one-entry valid/ready output buffer. It sits between a neuron (or synapse output) and any consumer of rate values, such as the top level's output pins or a later learning block.

---
 rtl/spike_rate_decoder.sv | 104 ++++++++++
 tb/tb_spike_rate_decoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts rising edges of spike_in over WINDOW_CYCLES enabled cycles and
// presents each count through a one-entry valid/ready buffer. Define SPIKE_ISI_EN to add isi_out.
module spike_rate_decoder #(
  parameter int WINDOW_CYCLES = 256,
  parameter int COUNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               spike_in,
  output logic [COUNT_W-1:0] rate_out,
  output logic               rate_valid,
  input  logic               rate_ready,
`ifdef SPIKE_ISI_EN
  output logic               overflow,
  output logic [15:0]        isi_out
`else
  output logic               overflow
`endif
);

  localparam int WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX  = '1;

  logic               r_spikePrev;
  logic [WIN_W-1:0]   r_winCnt;
  logic [COUNT_W-1:0] r_spkCnt;
  logic [COUNT_W-1:0] r_rate;
  logic               r_valid;
  logic               r_overflow;

  logic               w_event;
  logic               w_terminal;
  logic [COUNT_W-1:0] w_spkNext;

  assign w_event    = spike_in & ~r_spikePrev & enable;
  assign w_terminal = enable & (r_winCnt == WIN_LAST);
  // The terminal cycle's own event must land in the result being latched.
  assign w_spkNext  = (w_event && (r_spkCnt != CNT_MAX)) ? r_spkCnt + 1'b1 : r_spkCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_spikePrev <= 1'b0;
      r_winCnt    <= '0;
      r_spkCnt    <= '0;
      r_rate      <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_spikePrev <= spike_in;
      if (enable) begin
        if (w_terminal) begin
          r_winCnt <= '0;
          r_spkCnt <= '0;
        end else begin
          r_winCnt <= r_winCnt + 1'b1;
          r_spkCnt <= w_spkNext;
        end
      end
      // A full buffer that is not being drained loses the new result.
      if (w_terminal) begin
        if (!r_valid || rate_ready) begin
          r_rate  <= w_spkNext;
          r_valid <= 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (r_valid && rate_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rate_out   = r_rate;
  assign rate_valid = r_valid;
  assign overflow   = r_overflow;

`ifdef SPIKE_ISI_EN
  logic [15:0] r_isiCnt;
  logic [15:0] r_isiOut;
  logic        r_isiArmed;

  // The first event after reset only starts the interval measurement.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_isiCnt   <= '0;
      r_isiOut   <= '0;
      r_isiArmed <= 1'b0;
    end else if (w_event) begin
      r_isiCnt   <= 16'd1;
      r_isiArmed <= 1'b1;
      if (r_isiArmed) begin
        r_isiOut <= r_isiCnt;
      end
    end else if (enable && (r_isiCnt != 16'hFFFF)) begin
      r_isiCnt <= r_isiCnt + 16'd1;
    end
  end

  assign isi_out = r_isiOut;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder: directed windows with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_spike_rate_decoder;

  localparam int WIN   = 40;
  localparam int CW    = 4;
  localparam int MAXC  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          spike_in = 1'b0;
  logic          rate_ready = 1'b0;
  logic [CW-1:0] rate_out;
  logic          rate_valid;
  logic          overflow;
`ifdef SPIKE_ISI_EN
  logic [15:0]   isi_out;
`endif

  int errors = 0;
  int checks = 0;
  bit started = 0;

  spike_rate_decoder #(.WINDOW_CYCLES(WIN), .COUNT_W(CW)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .spike_in(spike_in),
    .rate_out(rate_out),
    .rate_valid(rate_valid),
    .rate_ready(rate_ready),
`ifdef SPIKE_ISI_EN
    .overflow(overflow),
    .isi_out(isi_out)
`else
    .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: positions and counts as plain integers, ISI as a difference of
  // enabled-cycle timestamps.
  int mPrev = 0, mPos = 0, mCount = 0, mRate = 0, mValid = 0, mOvf = 0;
  int mIsi = 0, mEnIdx = 0, mLastEvt = -1;
  bit mEvt, mTerm, mHs;

  always @(posedge clk) begin
    if (reset) begin
      mPrev = 0; mPos = 0; mCount = 0; mRate = 0; mValid = 0; mOvf = 0;
      mIsi = 0; mEnIdx = 0; mLastEvt = -1;
    end else begin
      mEvt  = spike_in && (mPrev == 0) && enable;
      mPrev = spike_in ? 1 : 0;
      mHs   = (mValid != 0) && rate_ready;
      mTerm = enable && (mPos == WIN - 1);
      if (mEvt) begin
        mCount = (mCount + 1 > MAXC) ? MAXC : mCount + 1;
        if (mLastEvt >= 0) mIsi = (mEnIdx - mLastEvt > 65535) ? 65535 : mEnIdx - mLastEvt;
        mLastEvt = mEnIdx;
      end
      if (mTerm) begin
        if (mValid == 0 || rate_ready) begin
          mRate = mCount;
          mValid = 1;
        end else begin
          mOvf = 1;
        end
        mCount = 0;
      end else if (mHs) begin
        mValid = 0;
      end
      if (enable) begin
        mPos = (mPos + 1) % WIN;
        mEnIdx++;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      checkOutput("model rate_out", int'(rate_out), mRate);
      checkOutput("model rate_valid", int'(rate_valid), mValid);
      checkOutput("model overflow", int'(overflow), mOvf);
`ifdef SPIKE_ISI_EN
      checkOutput("model isi_out", int'(isi_out), mIsi);
`endif
    end
  end

  // Drive one cycle's inputs; returns just after the edge that sampled them.
  task automatic applyStimulus(input logic sp, input logic en, input logic rdy, input logic rst);
    spike_in   = sp;
    enable     = en;
    rate_ready = rdy;
    reset      = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic runRange(input logic [WIN-1:0] pat, input int first, input int last, input logic rdy);
    for (int k = first; k <= last; k++) applyStimulus(pat[k], 1'b1, rdy, 1'b0);
  endtask

  logic [WIN-1:0] pat;

  initial begin
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    started = 1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("reset rate_valid", int'(rate_valid), 0);
    checkOutput("reset overflow", int'(overflow), 0);
    checkOutput("reset rate_out", int'(rate_out), 0);

    // Window 1: three two-cycle pulses.
    pat = '0; pat[2] = 1; pat[3] = 1; pat[10] = 1; pat[11] = 1; pat[20] = 1; pat[21] = 1;
    runRange(pat, 0, WIN - 2, 1'b1);
    checkOutput("w1 valid early", int'(rate_valid), 0);
    runRange(pat, WIN - 1, WIN - 1, 1'b1);
    checkOutput("w1 rate_out", int'(rate_out), 3);
    checkOutput("w1 rate_valid", int'(rate_valid), 1);

    // Window 2: silent except an edge on its terminal cycle.
    pat = '0; pat[WIN-1] = 1;
    runRange(pat, 0, 0, 1'b1);
    checkOutput("w1 consumed", int'(rate_valid), 0);
    checkOutput("w1 rate held", int'(rate_out), 3);
    runRange(pat, 1, WIN - 1, 1'b1);
    checkOutput("w2 terminal event", int'(rate_out), 1);

    // Window 3: line held high, no new edge.
    pat = '1;
    runRange(pat, 0, WIN - 1, 1'b1);
    checkOutput("w3 held level", int'(rate_out), 0);
    checkOutput("w3 rate_valid", int'(rate_valid), 1);

    // Windows 4 and 5 with a stalled consumer.
    pat = '0; pat[5] = 1; pat[15] = 1;
    runRange(pat, 0, 0, 1'b1);
    runRange(pat, 1, WIN - 1, 1'b0);
    checkOutput("w4 rate_out", int'(rate_out), 2);
    checkOutput("w4 overflow", int'(overflow), 0);
    pat = '0; pat[2] = 1; pat[6] = 1; pat[10] = 1; pat[14] = 1; pat[18] = 1;
    runRange(pat, 0, 2, 1'b0);
`ifdef SPIKE_ISI_EN
    checkOutput("isi across windows", int'(isi_out), 27);
`endif
    runRange(pat, 3, 6, 1'b0);
`ifdef SPIKE_ISI_EN
    checkOutput("isi 4", int'(isi_out), 4);
`endif
    runRange(pat, 7, WIN - 1, 1'b0);
    checkOutput("w5 rate kept", int'(rate_out), 2);
    checkOutput("w5 overflow", int'(overflow), 1);
    checkOutput("w5 rate_valid", int'(rate_valid), 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("drain rate_valid", int'(rate_valid), 0);
    checkOutput("overflow sticky", int'(overflow), 1);

    // Window 6: 20 edges saturate a 4-bit count; a 10-cycle pause stretches the window.
    pat = '0;
    for (int k = 0; k < WIN; k += 2) pat[k] = 1;
    runRange(pat, 0, 19, 1'b1);
    for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    runRange(pat, 20, WIN - 2, 1'b1);
    checkOutput("w6 not done", int'(rate_valid), 0);
    runRange(pat, WIN - 1, WIN - 1, 1'b1);
    checkOutput("w6 saturated", int'(rate_out), 15);
    checkOutput("w6 rate_valid", int'(rate_valid), 1);

    // Randomized traffic, including occasional mid-window resets.
    for (int n = 0; n < 4000; n++) begin
      applyStimulus(($urandom_range(0, 99) < 40) ? ~spike_in : spike_in,
                    $urandom_range(0, 99) < 90,
                    $urandom_range(0, 99) < 60,
                    $urandom_range(0, 499) == 0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("final reset overflow", int'(overflow), 0);
    checkOutput("final reset rate_out", int'(rate_out), 0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
